// File: rtl/prod_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum_pkg
// Description : Shared types and default sizing for the product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package prod_accum_pkg;

    // Two-state group controller: collecting beats, or presenting a sum
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int PROD_W_DEF = 4;
    localparam int COUNT_DEF  = 4;
    localparam int ACC_W_DEF  = 8;

endpackage : prod_accum_pkg
`default_nettype wire

// File: rtl/prod_accum_if.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum_if
// Description : Input product stream and output sum stream of prod_accum.
//               master = surrounding logic, slave = the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface prod_accum_if #(
    parameter int PROD_W = prod_accum_pkg::PROD_W_DEF,
    parameter int ACC_W  = prod_accum_pkg::ACC_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface : prod_accum_if
`default_nettype wire

// File: rtl/prod_accum_add.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum_add
// Description : Combinational accumulator adder, acc + zero-extended product,
//               with carry out of ACC_W. With PROD_ACCUM_SAT_EN defined the
//               sum clamps to all-ones on carry instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module prod_accum_add
    import prod_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  wire logic [ACC_W-1:0]  i_acc,
    input  wire logic [PROD_W-1:0] i_prod,
    output logic      [ACC_W-1:0]  o_sum,
    output logic                   o_carry
);

    logic [ACC_W:0] w_full;

    // Full-width add so the carry out of ACC_W is visible
    always_comb begin
        w_full  = {1'b0, i_acc} + {{(ACC_W+1-PROD_W){1'b0}}, i_prod};
        o_carry = w_full[ACC_W];
`ifdef PROD_ACCUM_SAT_EN
        // Clamp on carry; once at all-ones any nonzero add carries again,
        // so the clamp holds for the rest of the group
        o_sum   = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
        o_sum   = w_full[ACC_W-1:0];
`endif
    end

endmodule : prod_accum_add
`default_nettype wire

// File: rtl/prod_accum.sv
`default_nettype none
// ============================================================================
// Module      : prod_accum
// Description : Sums COUNT consecutive products from the 2x2 multiplier and
//               presents each group sum on a valid/ready port. Optional
//               saturation instead of wrap under PROD_ACCUM_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prod_accum
    import prod_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int COUNT  = COUNT_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      clear,
    prod_accum_if.slave    bus
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(COUNT - 1);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;

    logic [ACC_W-1:0]   w_sum;
    logic               w_carry;
    logic               w_accept;
    logic               w_ovf_next;

    prod_accum_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .i_acc   (r_acc),
        .i_prod  (bus.in_prod),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    assign w_accept   = bus.in_valid && r_in_ready;
    assign w_ovf_next = r_ovf | w_carry;

    // Group controller: accumulate beats, latch the sum, wait for the sink
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (clear) begin
            // Abort wins over any accept or output handshake this cycle
            r_state     <= ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_ovf <= w_ovf_next;
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt       <= '0;
                            r_state     <= HOLD;
                            r_out_sum   <= w_sum;
                            r_out_ovf   <= w_ovf_next;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_state     <= ACCUM;
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ACCUM;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_ovf   = r_out_ovf;

endmodule : prod_accum
`default_nettype wire
